// File: rtl/add_pipe_wrapper.sv
// add_pipe_wrapper: pipelined signed/unsigned add/subtract engine with a
// credit-controlled result FIFO, sticky issue-error flag and synchronous flush.
// An accepted start at edge E0 lands in the FIFO at edge E(LATENCY-1).
module add_pipe_wrapper #(
  parameter int DATA_W     = 16,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  ready,
  output logic [2*DATA_W-1:0]   s,
  output logic                  valid,
  input  logic                  rd,
  output logic                  done,
  output logic                  busy,
  input  logic                  flush,
  output logic                  err,
  input  logic                  clr_err
);

  localparam int RES_W = 2 * DATA_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(FIFO_DEPTH + LATENCY) + 1;

  // Exact result in 2*DATA_W bits: extend operands by one bit (sign or zero
  // depending on op[1]), add or subtract, then extend the (DATA_W+1)-bit
  // result. Only the unsigned add is zero-extended; every other op treats
  // bit DATA_W as a sign bit, so unsigned 0-1 yields all ones.
  function automatic logic [RES_W-1:0] arith(input logic [1:0]        f_op,
                                             input logic [DATA_W-1:0] f_a,
                                             input logic [DATA_W-1:0] f_b);
    logic [DATA_W:0] ax;
    logic [DATA_W:0] bx;
    logic [DATA_W:0] r;
    logic            fill;
    ax   = {f_op[1] & f_a[DATA_W-1], f_a};
    bx   = {f_op[1] & f_b[DATA_W-1], f_b};
    r    = f_op[0] ? (ax - bx) : (ax + bx);
    fill = (f_op != 2'b00) & r[DATA_W];
    return {{(DATA_W-1){fill}}, r};
  endfunction

  logic                  accept;
  logic                  wr_en;
  logic                  pop;
  logic [RES_W-1:0]      wr_data;
  logic [LATENCY-1:0]    vld_reg;
  logic [LATENCY-1:0]    vld_next;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [OUT_W-1:0]      outstanding;
  logic [RES_W-1:0]      mem [FIFO_DEPTH];
  logic [RES_W-1:0]      s_reg;
  logic [RES_W-1:0]      s_next;
  logic                  busy_reg;
  logic                  err_reg;

  // Credits: requests still in the pipe (not yet in the FIFO) plus FIFO fill.
  // The last valid bit is excluded because that request is already stored.
  always_comb begin
    outstanding = OUT_W'(count_reg);
    for (int i = 0; i < LATENCY - 1; i++) begin
      outstanding = outstanding + OUT_W'(vld_reg[i]);
    end
  end

  assign ready  = (outstanding < OUT_W'(FIFO_DEPTH)) & ~flush;
  assign accept = start & ready;
  assign valid  = (count_reg != '0);
  assign pop    = rd & valid & ~flush;

  // Valid chain: bit 0 fills on an accepted start, later bits shift along;
  // flush kills everything in flight.
  assign vld_next[0] = accept;
  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_vld
      assign vld_next[gi] = vld_reg[gi-1] & ~flush;
    end
  endgenerate

  // The FIFO is written at the same edge the last stage fills, so a result
  // is visible LATENCY edges after acceptance counting the accept edge.
  assign wr_en = vld_next[LATENCY-1];

  // Stage valid bits; the last one doubles as the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= vld_next;
    end
  end

  // Datapath: stage 0 holds operands, stage 1 computes, later stages carry
  // the finished result. The arithmetic is the same function at every depth.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign wr_data = arith(op, a, b);
    end else begin : g_pipe
      logic [DATA_W-1:0] a_reg;
      logic [DATA_W-1:0] b_reg;
      logic [1:0]        op_reg;

      // Operand capture on accepted issue.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_reg  <= '0;
          b_reg  <= '0;
          op_reg <= '0;
        end else if (accept) begin
          a_reg  <= a;
          b_reg  <= b;
          op_reg <= op;
        end
      end

      if (LATENCY == 2) begin : g_lat2
        assign wr_data = arith(op_reg, a_reg, b_reg);
      end else begin : g_latn
        logic [LATENCY-2:1][RES_W-1:0] res_reg;

        // Result stages; validity travels in vld_reg alongside.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            res_reg <= '0;
          end else begin
            res_reg[1] <= arith(op_reg, a_reg, b_reg);
            for (int i = 2; i <= LATENCY - 2; i++) begin
              res_reg[i] <= res_reg[i-1];
            end
          end
        end

        assign wr_data = res_reg[LATENCY-2];
      end
    end
  endgenerate

  // FIFO storage, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Fill level; a simultaneous write and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Registered head-of-FIFO value: the next head is the following entry
  // after a pop, the incoming result when the FIFO is (or becomes) empty,
  // and zero when nothing is left.
  always_comb begin
    s_next = s_reg;
    if (flush) begin
      s_next = '0;
    end else if (pop) begin
      if (count_reg > CNT_W'(1)) begin
        s_next = mem[rd_ptr_reg + PTR_W'(1)];
      end else begin
        s_next = wr_en ? wr_data : '0;
      end
    end else if (count_reg == '0) begin
      s_next = wr_en ? wr_data : '0;
    end
  end

  // FIFO pointers, count and head register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      s_reg      <= '0;
    end else begin
      count_reg <= count_next;
      s_reg     <= s_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Busy: any stage holds a request after this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= |vld_next;
    end
  end

  // Sticky error: a refused issue sets it (winning over clear); a flushed
  // issue is not an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if (start & ~ready & ~flush) begin
      err_reg <= 1'b1;
    end else if (clr_err) begin
      err_reg <= 1'b0;
    end
  end

  assign s    = s_reg;
  assign done = vld_reg[LATENCY-1];
  assign busy = busy_reg;
  assign err  = err_reg;

endmodule

// File: doc/add_pipe_wrapper.md
# add_pipe_wrapper

Parametrised, fully pipelined add/subtract engine for the Avalon slave arithmetic path. Unlike the single-shot wrapper, it accepts a new operand pair every cycle, supports signed and unsigned add/subtract, and buffers results in an internal FIFO that the slave front-end drains with a read strobe. Flow control is credit-based, so the FIFO never overflows. Illegal issues are flagged in a sticky error bit.

## Interface
- DATA_W, 16, operand width; at least 2.
- LATENCY, 3, register stages from operand capture to FIFO write; at least 1.
- FIFO_DEPTH, 4, result FIFO entries; a power of 2, at least 2.
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  issue request; accepted when start=1 and ready=1.
- op  in  2  operation: 00 unsigned add, 01 unsigned sub (a-b), 10 signed add, 11 signed sub.
- a, b  in  DATA_W  operands.
- ready  out  1  combinational; an issue is accepted this cycle.
- s  out  2*DATA_W  result at the FIFO head; 0 when valid=0.
- valid  out  1  FIFO not empty.
- rd  in  1  pop the FIFO head; ignored when valid=0.
- done  out  1  one-cycle pulse per result written into the FIFO.
- busy  out  1  at least one request in the pipeline.
- flush  in  1  synchronous clear of the pipeline and FIFO.
- err  out  1  sticky; set by a start while ready=0.
- clr_err  in  1  clears err.

## Operation
- Result arithmetic, exact in 2*DATA_W bits:
  - op 00: zero-extend a and b to DATA_W+1 bits, add, zero-extend the sum.
  - op 01: zero-extend both, subtract, sign-extend the (DATA_W+1)-bit difference. Example: 0-1 gives all ones.
  - op 10 / 11: sign-extend both to DATA_W+1 bits, add or subtract, sign-extend the result.
- Pipeline:
  - LATENCY stages, each holding a valid bit plus data.
  - Stage 0 captures operands and op on an accepted start.
  - The arithmetic may be split across stages, but the result is identical for any LATENCY.
- Credits:
  - outstanding = (valid bits set in the pipeline) + fifo_count.
  - ready = (outstanding < FIFO_DEPTH) and not flush.
  - A pop takes effect at the edge; it does not raise ready in the same cycle.
- FIFO:
  - Written when the last pipeline stage is valid; popped on rd with valid=1.
  - Simultaneous write and pop is legal at any fill level; fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Credits guarantee no write occurs when full.
- busy = OR of the pipeline valid bits, registered.
- done = registered copy of the last-stage valid bit, i.e. high in the cycle after the FIFO write.
- err:
  - Set at the edge where start=1, ready=0, flush=0.
  - Cleared by clr_err. If set and clear coincide, set wins.
- flush:
  - Clears all pipeline valid bits, the FIFO pointers, and the count.
  - A start in the same cycle is dropped and err is not set.
  - err is unchanged by flush.

## Timing
- Reset values:
  - ready=1, s=0, valid=0, done=0, busy=0, err=0.
  - Pipeline valid bits, pointers and count are 0.
- Latency: start accepted at edge E0 → FIFO write at edge E(LATENCY-1).
  - valid=1 and s correct immediately after that edge, when the FIFO was empty.
  - done is high from E(LATENCY-1) to E(LATENCY).
- busy rises at E0 and falls after the last in-flight result is written.
- Throughput: one accepted start per cycle while ready=1.
- Pop at edge E: the next entry (or 0 when empty) appears on s after E.
- Reset asserted mid-operation immediately forces all outputs to reset values.
  - In-flight requests are lost.
  - Operation resumes on the first edge after deassertion.

## Test plan
- **Single add**, DATA_W=16: op=00, a=0xFFFF, b=0x0001, rd=0 → after LATENCY edges valid=1, s=0x00010000, done pulses once, busy returns to 0.
- **Signed and unsigned sub:**
  - op=01, a=0, b=1 → s=0xFFFFFFFF.
  - op=11, a=0x8000, b=0x0001 → s=0xFFFF7FFF.
  - op=10, a=0x7FFF, b=0x7FFF → s=0x0000FFFE.
- **Back-to-back fill**, rd=0: 5 consecutive starts with a=1..5, b=0 → first 4 accepted; ready=0 from the 4th acceptance onward; 5th sets err; the FIFO pops in order 1, 2, 3, 4.
- **Streaming:** continuous starts with rd held high → after fill latency, one result per cycle with no drops; err stays 0.
- **Flush with start:** flush and start in the same cycle with 2 requests in flight → valid=0, busy=0 next cycle; no done pulses; err unchanged.
- **Async reset:** assert reset_n low mid-burst, between edges → outputs reach reset values without a clock edge; the first start after release produces a correct result after LATENCY edges.
